// File: rtl/inst_fetch_if.sv
// inst_fetch_if: fetch-stage bus; master=inst_fetch (imem_req/imem_addr, inst_valid/inst/op/pc/pc_plus4), slave=imem + decoder (gnt/rvalid/rdata, inst_ready/branch/jump/zero)
interface inst_fetch_if #(parameter int PC_W = 32);
  logic imem_req;
  logic [PC_W-1:0] imem_addr;
  logic imem_gnt;
  logic imem_rvalid;
  logic [31:0] imem_rdata;
  logic inst_valid;
  logic inst_ready;
  logic [31:0] inst;
  logic [5:0] op;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic branch;
  logic jump;
  logic zero;
  modport master (
    output imem_req, imem_addr, inst_valid, inst, op, pc, pc_plus4,
    input imem_gnt, imem_rvalid, imem_rdata, inst_ready, branch, jump, zero
  );
  modport slave (
    input imem_req, imem_addr, inst_valid, inst, op, pc, pc_plus4,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, branch, jump, zero
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: PC + imem req/gnt/rvalid fetch FSM feeding the decoder; ports clk, rst (sync active-low), bus (inst_fetch_if.master)
module inst_fetch #(
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  inst_fetch_if.master bus
);
  typedef enum logic [1:0] {FETCH, WAIT, ISSUE} state_t;
  state_t state;
  logic [PC_W-1:0] pc, pc_plus4, next_pc;
  logic [31:0] inst;
  logic inst_valid, imem_req;
  assign pc_plus4 = pc + PC_W'(4);
  assign next_pc = bus.jump ? {pc_plus4[PC_W-1:28], inst[25:0], 2'b00}
                 : (bus.branch && bus.zero) ? pc_plus4 + {{(PC_W-18){inst[15]}}, inst[15:0], 2'b00}
                 : pc_plus4;
  always_ff @(posedge clk)
    if (!rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      inst <= '0;
      inst_valid <= 1'b0;
      imem_req <= 1'b0;
    end else
      case (state)
        FETCH:
          if (imem_req && bus.imem_gnt) begin
            state <= WAIT;
            imem_req <= 1'b0;
          end else
            imem_req <= 1'b1;
        WAIT:
          if (bus.imem_rvalid) begin
            inst <= bus.imem_rdata;
            inst_valid <= 1'b1;
            state <= ISSUE;
          end
        ISSUE:
          if (bus.inst_ready) begin
            pc <= next_pc;
            inst_valid <= 1'b0;
            imem_req <= 1'b1;
            state <= FETCH;
          end
        default: state <= FETCH;
      endcase
  assign bus.imem_req = imem_req;
  assign bus.imem_addr = pc;
  assign bus.inst_valid = inst_valid;
  assign bus.inst = inst;
  assign bus.op = inst_valid ? inst[31:26] : 6'b111111;
  assign bus.pc = pc;
  assign bus.pc_plus4 = pc_plus4;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch driving the imem and decoder sides of inst_fetch_if
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [31:0] mpc = '0;
  logic [63:0] exp_q[$];
  inst_fetch_if #(.PC_W(32)) bus();
  inst_fetch #(.PC_W(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic fetch(input logic [31:0] w, input int gd, input int rd, input int hold,
                       input logic b, input logic j, input logic z, input logic stray);
    int t, c0;
    logic [63:0] e;
    logic [31:0] ep, ei, pp4;
    t = 0;
    while (bus.imem_req !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      failures++;
      $display("FAIL req_timeout got=%b exp=1", bus.imem_req);
    end
    checks++;
    if (bus.imem_addr !== mpc) begin
      failures++;
      $display("FAIL imem_addr got=%h exp=%h", bus.imem_addr, mpc);
    end
    c0 = cyc;
    repeat (gd) @(negedge clk);
    bus.imem_gnt = 1'b1;
    if (stray) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = ~w;
    end
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_state got req=%b valid=%b exp req=0 valid=0", bus.imem_req, bus.inst_valid);
    end
    repeat (rd) @(negedge clk);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = w;
    exp_q.push_back({mpc, w});
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    if (gd == 0 && rd == 0) begin
      checks++;
      if (cyc - c0 != 2 || bus.inst_valid !== 1'b1) begin
        failures++;
        $display("FAIL latency got=%0d valid=%b exp=2 valid=1", cyc - c0, bus.inst_valid);
      end
    end
    checks++;
    if (bus.inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL inst_valid got=%b exp=1", bus.inst_valid);
    end
    e = exp_q.pop_front();
    ep = e[63:32];
    ei = e[31:0];
    checks++;
    if (bus.inst !== ei || bus.op !== ei[31:26] || bus.pc !== ep || bus.pc_plus4 !== ep + 32'd4) begin
      failures++;
      $display("FAIL issue got inst=%h op=%h pc=%h pc4=%h exp inst=%h op=%h pc=%h pc4=%h",
               bus.inst, bus.op, bus.pc, bus.pc_plus4, ei, ei[31:26], ep, ep + 32'd4);
    end
    for (int i = 0; i < hold; i++) begin
      bus.branch = 1'b1;
      bus.jump = 1'b1;
      bus.zero = 1'b1;
      if (stray) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = ~w;
      end
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      checks++;
      if (bus.inst !== ei || bus.op !== ei[31:26] || bus.pc !== ep || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold got inst=%h op=%h pc=%h req=%b valid=%b exp inst=%h op=%h pc=%h req=0 valid=1",
                 bus.inst, bus.op, bus.pc, bus.imem_req, bus.inst_valid, ei, ei[31:26], ep);
      end
    end
    pp4 = ep + 32'd4;
    mpc = j ? {pp4[31:28], ei[25:0], 2'b00}
        : (b && z) ? pp4 + (32'($signed(ei[15:0])) << 2)
        : pp4;
    bus.inst_ready = 1'b1;
    bus.branch = b;
    bus.jump = j;
    bus.zero = z;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    bus.branch = 1'b0;
    bus.jump = 1'b0;
    bus.zero = 1'b0;
    last_acc = cyc;
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.op !== 6'h3f || bus.pc !== mpc) begin
      failures++;
      $display("FAIL accept got valid=%b op=%h pc=%h exp valid=0 op=3f pc=%h", bus.inst_valid, bus.op, bus.pc, mpc);
    end
  endtask
  task automatic check_pc(input logic [31:0] want);
    checks++;
    if (bus.pc !== want) begin
      failures++;
      $display("FAIL next_pc got=%h exp=%h", bus.pc, want);
    end
  endtask
  task automatic test_reset();
    rst = 1'b0;
    bus.imem_gnt = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    bus.inst_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.pc !== 32'h0 || bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.inst !== 32'h0 || bus.op !== 6'h3f) begin
      failures++;
      $display("FAIL reset got pc=%h valid=%b req=%b inst=%h op=%h exp pc=0 valid=0 req=0 inst=0 op=3f",
               bus.pc, bus.inst_valid, bus.imem_req, bus.inst, bus.op);
    end
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.inst_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL post_reset got req=%b addr=%h exp req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
    mpc = 32'h0;
  endtask
  task automatic test_sequential();
    fetch(32'h8C01_0004, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pc(32'h4);
  endtask
  task automatic test_branch();
    fetch(32'h0000_0000, 2, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_pc(32'h8);
    fetch(32'h1000_FFFE, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_pc(32'h4);
    fetch(32'h0000_0000, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(32'h1000_FFFE, 0, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_pc(32'hC);
  endtask
  task automatic test_wrap();
    fetch(32'h1000_FFFB, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_pc(32'hFFFF_FFFC);
    fetch(32'h0000_0000, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_pc(32'h0);
  endtask
  task automatic test_jump();
    fetch(32'h0BFF_FFFF, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_pc(32'h0FFF_FFFC);
    fetch(32'h0800_0004, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_pc(32'h1000_0010);
    fetch(32'h0800_0040, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_pc(32'h1000_0100);
  endtask
  task automatic test_backpressure();
    fetch(32'h2002_0005, 0, 0, 5, 1'b0, 1'b0, 1'b0, 1'b1);
    check_pc(32'h1000_0104);
  endtask
  task automatic test_abort();
    int t;
    t = 0;
    while (bus.imem_req !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    rst = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b1;
    bus.imem_rvalid = 1'b0;
    checks++;
    if (bus.pc !== 32'h0 || bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0 || bus.inst !== 32'h0) begin
      failures++;
      $display("FAIL abort got pc=%h valid=%b req=%b inst=%h exp pc=0 valid=0 req=0 inst=0",
               bus.pc, bus.inst_valid, bus.imem_req, bus.inst);
    end
    mpc = 32'h0;
  endtask
  task automatic test_back_to_back();
    int prev;
    fetch(32'h0000_0020, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      prev = last_acc;
      fetch(32'h0000_0020 + 32'(i), 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (last_acc - prev != 3) begin
        failures++;
        $display("FAIL throughput got=%0d exp=3", last_acc - prev);
      end
    end
    check_pc(32'h10);
  endtask
  initial begin
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.inst_ready = 1'b0;
    bus.branch = 1'b0;
    bus.jump = 1'b0;
    bus.zero = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_jump();
    test_backpressure();
    test_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
